// File: rtl/mmio_controller_if.sv
// Data-memory side bus of the MMIO block: request fields in,
// registered read data and misalignment flag out.
interface mmio_controller_if;
  logic        sel;
  logic [31:0] address;
  logic        wren;
  logic [1:0]  mem_mode;
  logic        mem_unsigned;
  logic [31:0] data;
  logic [31:0] q;
  logic        misaligned;

  modport master (
    output sel,
    output address,
    output wren,
    output mem_mode,
    output mem_unsigned,
    output data,
    input  q,
    input  misaligned
  );

  modport slave (
    input  sel,
    input  address,
    input  wren,
    input  mem_mode,
    input  mem_unsigned,
    input  data,
    output q,
    output misaligned
  );
endinterface

// File: rtl/mmio_controller.sv
// Memory-mapped GPIO block: output registers, synchronised inputs
// with edge capture, write-1-to-clear pending bits and a level irq.
module mmio_controller #(
  parameter int NUM_OUT = 2,
  parameter int NUM_IN  = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  mmio_controller_if.slave      bus,
  input  logic [NUM_IN-1:0]     io_input_bus,
  output logic [32*NUM_OUT-1:0] io_output_bus,
  output logic                  irq
);

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;

  localparam logic [4:0] IDX_LEVEL = 5'd16;
  localparam logic [4:0] IDX_PEND  = 5'd17;
  localparam logic [4:0] IDX_EN    = 5'd18;
  localparam logic [4:0] IDX_FALL  = 5'd19;

  typedef logic [NUM_IN-1:0] in_t;

  function automatic logic [31:0] widen(input in_t v);
    logic [31:0] w;
    w = '0;
    w[NUM_IN-1:0] = v;
    return w;
  endfunction

  logic [4:0]  idx;
  logic [1:0]  off;
  logic        is_byte;
  logic        is_half;
  logic [3:0]  be;
  logic        aligned;
  logic        hit_out;
  logic        hit_level;
  logic        hit_pend;
  logic        hit_en;
  logic        hit_fall;
  logic        mapped;
  logic        bad;
  logic        do_write;
  logic [31:0] wmask;
  logic [31:0] wdata;
  logic [31:0] wbits;
  logic [31:0] rd_word;
  logic        unused_addr;

  logic [31:0] out_reg [NUM_OUT];
  in_t         sync1;
  in_t         level;
  in_t         prev;
  in_t         pend;
  in_t         irq_en;
  in_t         fall_sel;
  in_t         edges;
  in_t         clr;
  in_t         en_nxt;
  in_t         fall_nxt;
  logic [31:0] en_m;
  logic [31:0] fall_m;

  logic        rd_live;
  logic        bad_r;
  logic        uns_r;
  logic [1:0]  off_r;
  logic [1:0]  mode_r;
  logic [31:0] word_r;
  logic [31:0] shifted;

  assign idx         = bus.address[6:2];
  assign off         = bus.address[1:0];
  assign unused_addr = ^bus.address[31:7];
  assign is_byte     = bus.mem_mode == MODE_BYTE;
  assign is_half     = bus.mem_mode == MODE_HALF;

  // Mode 3 is not a defined access size; it decodes as a word.
  always_comb begin
    be      = 4'b1111;
    aligned = 1'b1;
    unique case (1'b1)
      is_byte: be = 4'b0001 << off;
      is_half: begin
        be      = 4'b0011 << off;
        aligned = ~off[0];
      end
      default: aligned = off == 2'd0;
    endcase
  end

  assign wmask = {{8{be[3]}}, {8{be[2]}},
                  {8{be[1]}}, {8{be[0]}}};
  assign wdata = bus.data << {off, 3'b000};
  assign wbits = wdata & wmask;

  assign hit_out   = idx < 5'(NUM_OUT);
  assign hit_level = idx == IDX_LEVEL;
  assign hit_pend  = idx == IDX_PEND;
  assign hit_en    = idx == IDX_EN;
  assign hit_fall  = idx == IDX_FALL;
  assign mapped    = hit_out | hit_level | hit_pend
                   | hit_en | hit_fall;

  assign bad      = bus.sel & mapped & ~aligned;
  assign do_write = bus.sel & bus.wren & aligned;

  assign edges = (fall_sel & ~level & prev)
               | (~fall_sel & level & ~prev);

  assign en_m   = (widen(irq_en) & ~wmask) | wbits;
  assign fall_m = (widen(fall_sel) & ~wmask) | wbits;

  always_comb begin
    en_nxt   = irq_en;
    fall_nxt = fall_sel;
    clr      = '0;
    if (do_write & hit_en) en_nxt = en_m[NUM_IN-1:0];
    if (do_write & hit_fall) fall_nxt = fall_m[NUM_IN-1:0];
    if (do_write & hit_pend) clr = wbits[NUM_IN-1:0];
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (idx == 5'(k)) rd_word = out_reg[k];
    end
    unique case (1'b1)
      hit_level: rd_word = widen(level);
      hit_pend:  rd_word = widen(pend);
      hit_en:    rd_word = widen(irq_en);
      hit_fall:  rd_word = widen(fall_sel);
      default:   ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) out_reg[k] <= '0;
      sync1    <= '0;
      level    <= '0;
      prev     <= '0;
      pend     <= '0;
      irq_en   <= '0;
      fall_sel <= '0;
    end else begin
      sync1    <= io_input_bus;
      level    <= sync1;
      prev     <= level;
      // A fresh edge overrides a same-cycle clear.
      pend     <= (pend & ~clr) | edges;
      irq_en   <= en_nxt;
      fall_sel <= fall_nxt;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (do_write && idx == 5'(k)) begin
          out_reg[k] <= (out_reg[k] & ~wmask) | wbits;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_live <= 1'b0;
      bad_r   <= 1'b0;
      uns_r   <= 1'b0;
      off_r   <= '0;
      mode_r  <= '0;
      word_r  <= '0;
    end else begin
      rd_live <= bus.sel & aligned;
      bad_r   <= bad;
      uns_r   <= bus.mem_unsigned;
      off_r   <= off;
      mode_r  <= bus.mem_mode;
      word_r  <= rd_word;
    end
  end

  assign shifted = word_r >> {off_r, 3'b000};

  always_comb begin
    bus.q = '0;
    if (rd_live) begin
      unique case (1'b1)
        mode_r == MODE_BYTE:
          bus.q = {{24{~uns_r & shifted[7]}}, shifted[7:0]};
        mode_r == MODE_HALF:
          bus.q = {{16{~uns_r & shifted[15]}}, shifted[15:0]};
        default:
          bus.q = shifted;
      endcase
    end
  end

  assign bus.misaligned = bad_r;
  assign irq            = |(pend & irq_en);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign io_output_bus[32*k +: 32] = out_reg[k];
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: directed register scenarios plus random
// traffic, all outputs compared every cycle against a register-file model.
module tb_mmio_controller;
  localparam int NOUT = 2;
  localparam int NIN  = 14;
  localparam logic [31:0] IMASK = 32'((64'd1 << NIN) - 1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NIN-1:0]       in_bus = '0;
  logic [32*NOUT-1:0]   out_bus;
  logic                 irq;

  mmio_controller_if bus_if ();

  mmio_controller #(.NUM_OUT(NOUT), .NUM_IN(NIN)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus_if),
    .io_input_bus  (in_bus),
    .io_output_bus (out_bus),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: register file as plain arrays, inputs as a sample history.
  logic [31:0]    m_out [NOUT];
  logic [31:0]    m_pend, m_en, m_fall;
  logic [NIN-1:0] m_hist [$];
  logic [31:0]    e_q;
  logic           e_mis;
  bit             m_live = 0;

  function automatic logic [31:0] m_read(input int idx);
    if (idx < NOUT) return m_out[idx];
    case (idx)
      16: return 32'(m_hist[1]);
      17: return m_pend;
      18: return m_en;
      19: return m_fall;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin : model
    int idx, off, size, lane;
    bit aligned, mapped, lv, pv;
    logic [31:0] rw, v, clr, edg;
    logic [7:0] b;
    if (reset) begin
      foreach (m_out[k]) m_out[k] = '0;
      m_pend = 0; m_en = 0; m_fall = 0;
      m_hist = {};
      repeat (3) m_hist.push_back('0);
      e_q = 0; e_mis = 0; m_live = 1;
    end else begin
      idx  = int'(bus_if.address[6:2]);
      off  = int'(bus_if.address[1:0]);
      size = (bus_if.mem_mode == 0) ? 1 : (bus_if.mem_mode == 1) ? 2 : 4;
      aligned = (off % size) == 0;
      mapped  = (idx < NOUT) || (idx >= 16 && idx <= 19);
      edg = 0;
      for (int i = 0; i < NIN; i++) begin
        lv = m_hist[1][i];
        pv = m_hist[2][i];
        if (m_fall[i] ? (!lv && pv) : (lv && !pv)) edg[i] = 1'b1;
      end
      rw    = m_read(idx);
      e_mis = bus_if.sel && mapped && !aligned;
      e_q   = 0;
      if (bus_if.sel && aligned) begin
        v = rw >> (8 * off);
        if (size == 1) begin
          v = v & 32'hFF;
          if (!bus_if.mem_unsigned && v[7]) v = v | 32'hFFFFFF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (!bus_if.mem_unsigned && v[15]) v = v | 32'hFFFF0000;
        end
        e_q = v;
      end
      clr = 0;
      if (bus_if.sel && bus_if.wren && aligned && mapped) begin
        for (int j = 0; j < size; j++) begin
          lane = off + j;
          b = bus_if.data[8*j +: 8];
          if (idx < NOUT) m_out[idx][8*lane +: 8] = b;
          else if (idx == 17) clr[8*lane +: 8] = b;
          else if (idx == 18) m_en[8*lane +: 8] = b;
          else if (idx == 19) m_fall[8*lane +: 8] = b;
        end
      end
      m_en   = m_en & IMASK;
      m_fall = m_fall & IMASK;
      m_pend = ((m_pend & ~clr) | edg) & IMASK;
      m_hist.push_front(in_bus);
      void'(m_hist.pop_back());
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      check("q", bus_if.q, e_q);
      check("misaligned", bus_if.misaligned, e_mis);
      check("irq", irq, |(m_pend & m_en));
      check("io_output_bus", out_bus, {m_out[1], m_out[0]});
    end
  end

  task automatic drive(input bit s, input bit w, input int idx,
                       input int off, input int mode, input bit uns,
                       input logic [31:0] d);
    bus_if.sel          = s;
    bus_if.wren         = w;
    bus_if.address      = 32'(idx * 4 + off);
    bus_if.mem_mode     = 2'(mode);
    bus_if.mem_unsigned = uns;
    bus_if.data         = d;
  endtask

  task automatic req(input bit w, input int idx, input int off,
                     input int mode, input bit uns, input logic [31:0] d);
    drive(1'b1, w, idx, off, mode, uns, d);
    @(negedge clock);
    drive(1'b0, 1'b0, 0, 0, 2, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int idx;
    drive(1'b0, 1'b0, 0, 0, 2, 1'b0, 32'h0);
    reset = 1'b1;
    idle(2);
    check("rst_q", bus_if.q, 0);
    check("rst_mis", bus_if.misaligned, 0);
    check("rst_irq", irq, 0);
    check("rst_bus", out_bus, 0);
    reset = 1'b0;
    idle(1);

    req(1, 1, 0, 2, 0, 32'hDEADBEEF);
    req(0, 1, 3, 0, 0, 0);
    check("byte_signed", bus_if.q, 32'hFFFFFFDE);
    req(0, 1, 3, 0, 1, 0);
    check("byte_unsigned", bus_if.q, 32'h000000DE);

    req(1, 0, 0, 2, 0, 32'h11223344);
    req(1, 0, 2, 0, 0, 32'h0000005A);
    check("byte_write_bus", out_bus[31:0], 32'h115A3344);
    req(0, 0, 0, 2, 0, 0);
    check("byte_write_rd", bus_if.q, 32'h115A3344);

    req(1, 18, 0, 2, 0, 32'h8);
    in_bus[3] = 1'b1;
    idle(2);
    check("edge_early_irq", irq, 0);
    idle(1);
    check("edge_irq", irq, 1);
    check("model_pend", m_pend, 32'h8);
    req(0, 17, 0, 2, 0, 0);
    check("pend_rd", bus_if.q, 32'h8);
    req(1, 17, 0, 2, 0, 32'h8);
    check("w1c_irq", irq, 0);

    in_bus[3] = 1'b0;
    idle(4);
    in_bus[3] = 1'b1;
    idle(2);
    req(1, 17, 0, 2, 0, 32'h8);
    check("edge_wins_irq", irq, 1);
    req(0, 17, 0, 2, 0, 0);
    check("edge_wins_rd", bus_if.q, 32'h8);
    req(1, 17, 0, 2, 0, 32'h8);
    check("w1c2_irq", irq, 0);

    req(1, 0, 1, 1, 0, 32'hFFFF);
    check("half_mis", bus_if.misaligned, 1);
    check("half_mis_q", bus_if.q, 0);
    idle(1);
    check("half_mis_end", bus_if.misaligned, 0);
    req(0, 0, 0, 2, 0, 0);
    check("half_mis_keep", bus_if.q, 32'h115A3344);
    req(1, 0, 2, 2, 0, 32'hFFFFFFFF);
    check("word_mis", bus_if.misaligned, 1);
    check("word_mis_q", bus_if.q, 0);
    idle(1);
    check("word_mis_end", bus_if.misaligned, 0);
    req(0, 0, 0, 2, 0, 0);
    check("word_mis_keep", bus_if.q, 32'h115A3344);

    in_bus[3] = 1'b0;
    idle(4);
    in_bus[3] = 1'b1;
    idle(4);
    check("pre_rst_irq", irq, 1);
    in_bus = '0;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1, 0, 2, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 2, 1'b0, 32'h0);
    check("mid_rst_q", bus_if.q, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_bus", out_bus, 0);
    req(0, 18, 0, 2, 0, 0);
    check("mid_rst_en", bus_if.q, 0);
    req(0, 17, 0, 2, 0, 0);
    check("mid_rst_pend", bus_if.q, 0);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      case ($urandom_range(0, 9))
        0: idx = 0;
        1: idx = 1;
        2, 3, 4, 5: idx = 16 + int'($urandom_range(0, 3));
        6: idx = 2;
        7: idx = int'($urandom_range(20, 31));
        default: idx = int'($urandom_range(0, 31));
      endcase
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), idx,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), $urandom());
      if ($urandom_range(0, 3) == 0) begin
        in_bus[$urandom_range(0, NIN-1)] ^= 1'b1;
      end
      @(negedge clock);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 2, 1'b0, 32'h0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
